// File: rtl/lsu_ctrl_if.sv
// Execute-stage, data-memory and writeback signals of the load/store unit.
// master = pipeline/memory side, slave = lsu_ctrl.
interface lsu_ctrl_if;
    logic        ex_valid;
    logic        ex_we;
    logic [1:0]  ex_size;
    logic        ex_signed;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        lsu_busy;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    logic        wb_valid;
    logic [31:0] wb_data;
    logic        exc_misalign;
    logic        exc_timeout;

    modport master (
        output ex_valid, ex_we, ex_size, ex_signed, ex_addr, ex_wdata,
        output dm_ack, dm_rdata,
        input  lsu_busy, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        input  wb_valid, wb_data, exc_misalign, exc_timeout
    );

    modport slave (
        input  ex_valid, ex_we, ex_size, ex_signed, ex_addr, ex_wdata,
        input  dm_ack, dm_rdata,
        output lsu_busy, dm_req, dm_we, dm_addr, dm_be, dm_wdata,
        output wb_valid, wb_data, exc_misalign, exc_timeout
    );
endinterface

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: one access at a time, lane steering for byte/half
// stores, load extraction with sign/zero extension, and a bounded wait for dm_ack.
module lsu_ctrl #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    lsu_ctrl_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [7:0] CNT_LAST = 8'(WAIT_MAX - 1);

    logic [1:0]  state_q,        state_d;
    logic [7:0]  cnt_q,          cnt_d;
    logic [1:0]  size_q,         size_d;
    logic        signed_q,       signed_d;
    logic [1:0]  lane_q,         lane_d;
    logic        dm_req_q,       dm_req_d;
    logic        dm_we_q,        dm_we_d;
    logic [31:0] dm_addr_q,      dm_addr_d;
    logic [3:0]  dm_be_q,        dm_be_d;
    logic [31:0] dm_wdata_q,     dm_wdata_d;
    logic        wb_valid_q,     wb_valid_d;
    logic [31:0] wb_data_q,      wb_data_d;
    logic        exc_misalign_q, exc_misalign_d;
    logic        exc_timeout_q,  exc_timeout_d;

    logic        misaligned;
    logic        accept;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_ext;

    always_comb begin
        misaligned = 1'b0;
        case (bus.ex_size)
            SZ_WORD: misaligned = (bus.ex_addr[1:0] != 2'b00);
            SZ_HALF: misaligned = bus.ex_addr[0];
            SZ_BYTE: misaligned = 1'b0;
            default: misaligned = 1'b1;
        endcase
    end

    assign accept       = (state_q == S_IDLE) && bus.ex_valid && !misaligned;
    // Gated by rst so the stall request is low for the whole reset cycle.
    assign bus.lsu_busy = !rst && ((state_q != S_IDLE) || accept);

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = bus.ex_wdata;
        case (bus.ex_size)
            SZ_BYTE: begin
                be_new    = 4'b0001 << bus.ex_addr[1:0];
                wdata_new = {4{bus.ex_wdata[7:0]}};
            end
            SZ_HALF: begin
                be_new    = bus.ex_addr[1] ? 4'b1100 : 4'b0011;
                wdata_new = {2{bus.ex_wdata[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = bus.ex_wdata;
            end
        endcase
    end

    always_comb begin
        rd_byte = bus.dm_rdata[7:0];
        case (lane_q)
            2'd0:    rd_byte = bus.dm_rdata[7:0];
            2'd1:    rd_byte = bus.dm_rdata[15:8];
            2'd2:    rd_byte = bus.dm_rdata[23:16];
            default: rd_byte = bus.dm_rdata[31:24];
        endcase
        rd_half = lane_q[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];

        load_ext = bus.dm_rdata;
        case (size_q)
            SZ_BYTE: load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
            SZ_HALF: load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
            default: load_ext = bus.dm_rdata;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        size_d         = size_q;
        signed_d       = signed_q;
        lane_d         = lane_q;
        dm_req_d       = dm_req_q;
        dm_we_d        = dm_we_q;
        dm_addr_d      = dm_addr_q;
        dm_be_d        = dm_be_q;
        dm_wdata_d     = dm_wdata_q;
        wb_valid_d     = 1'b0;
        wb_data_d      = wb_data_q;
        exc_misalign_d = 1'b0;
        exc_timeout_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid) begin
                    if (misaligned) begin
                        exc_misalign_d = 1'b1;
                    end else begin
                        state_d    = S_REQ;
                        cnt_d      = '0;
                        size_d     = bus.ex_size;
                        signed_d   = bus.ex_signed;
                        lane_d     = bus.ex_addr[1:0];
                        dm_req_d   = 1'b1;
                        dm_we_d    = bus.ex_we;
                        dm_addr_d  = {bus.ex_addr[31:2], 2'b00};
                        dm_be_d    = be_new;
                        dm_wdata_d = wdata_new;
                    end
                end
            end
            S_REQ: begin
                // An ack on the last allowed cycle wins over the timeout.
                if (bus.dm_ack) begin
                    state_d  = S_DONE;
                    dm_req_d = 1'b0;
                    if (!dm_we_q) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = load_ext;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = S_IDLE;
                    dm_req_d      = 1'b0;
                    exc_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                dm_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            size_q         <= '0;
            signed_q       <= 1'b0;
            lane_q         <= '0;
            dm_req_q       <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_addr_q      <= '0;
            dm_be_q        <= '0;
            dm_wdata_q     <= '0;
            wb_valid_q     <= 1'b0;
            wb_data_q      <= '0;
            exc_misalign_q <= 1'b0;
            exc_timeout_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            size_q         <= size_d;
            signed_q       <= signed_d;
            lane_q         <= lane_d;
            dm_req_q       <= dm_req_d;
            dm_we_q        <= dm_we_d;
            dm_addr_q      <= dm_addr_d;
            dm_be_q        <= dm_be_d;
            dm_wdata_q     <= dm_wdata_d;
            wb_valid_q     <= wb_valid_d;
            wb_data_q      <= wb_data_d;
            exc_misalign_q <= exc_misalign_d;
            exc_timeout_q  <= exc_timeout_d;
        end
    end

    assign bus.dm_req       = dm_req_q;
    assign bus.dm_we        = dm_we_q;
    assign bus.dm_addr      = dm_addr_q;
    assign bus.dm_be        = dm_be_q;
    assign bus.dm_wdata     = dm_wdata_q;
    assign bus.wb_valid     = wb_valid_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.exc_misalign = exc_misalign_q;
    assign bus.exc_timeout  = exc_timeout_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset sequences and random
// operations checked against a rule-level model of lane steering and extension.
module tb_lsu_ctrl;
    localparam int unsigned WMAX = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lsu_ctrl_if bus();

    lsu_ctrl #(.WAIT_MAX(WMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_wb;

    typedef struct {
        string       name;
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int unsigned delay;
        logic        mis;
        logic [3:0]  be;
        logic [31:0] exp_wd;
        logic [31:0] exp_wb;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference rules, written directly from the access-size definitions.
    function automatic logic m_mis(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b00 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] a);
        if (size == 2'b10) return 4'b0001 << a[1:0];
        if (size == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wd(input logic [1:0] size, input logic [31:0] w);
        if (size == 2'b10) return {4{w[7:0]}};
        if (size == 2'b01) return {2{w[15:0]}};
        return w;
    endfunction

    function automatic logic [31:0] m_ld(input logic [1:0] size, input logic sg,
                                         input logic [31:0] a, input logic [31:0] r);
        logic [31:0] v;
        v = r;
        if (size == 2'b10) begin
            v = (r >> (32'(a[1:0]) * 8)) & 32'h0000_00FF;
            if (sg && v[7]) v = v | 32'hFFFF_FF00;
        end else if (size == 2'b01) begin
            v = (r >> (32'(a[1]) * 16)) & 32'h0000_FFFF;
            if (sg && v[15]) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic check_zero(input string tag);
        chk({tag, " dm_req"},   32'(bus.dm_req), 32'd0);
        chk({tag, " dm_we"},    32'(bus.dm_we), 32'd0);
        chk({tag, " dm_addr"},  bus.dm_addr, 32'd0);
        chk({tag, " dm_be"},    32'(bus.dm_be), 32'd0);
        chk({tag, " dm_wdata"}, bus.dm_wdata, 32'd0);
        chk({tag, " wb_valid"}, 32'(bus.wb_valid), 32'd0);
        chk({tag, " wb_data"},  bus.wb_data, 32'd0);
        chk({tag, " exc_mis"},  32'(bus.exc_misalign), 32'd0);
        chk({tag, " exc_to"},   32'(bus.exc_timeout), 32'd0);
        chk({tag, " busy"},     32'(bus.lsu_busy), 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        logic        acked;
        logic        tmo;
        int unsigned nreq, nbusy, nwb, nmis, nto, bad;
        int          wb_idx, mis_idx;
        logic [31:0] wb_seen, ad_seen, wd_seen;
        logic [3:0]  be_seen;
        logic        we_seen;
        acked = !v.mis && (v.delay <= WMAX);
        tmo   = !v.mis && (v.delay > WMAX);
        nreq = 0; nbusy = 0; nwb = 0; nmis = 0; nto = 0; bad = 0;
        wb_idx = -1; mis_idx = -1;
        wb_seen = '0; ad_seen = '0; wd_seen = '0; be_seen = '0; we_seen = 1'b0;

        @(negedge clk);
        bus.dm_ack    = 1'b0;
        bus.ex_we     = v.we;
        bus.ex_size   = v.size;
        bus.ex_signed = v.sgn;
        bus.ex_addr   = v.addr;
        bus.ex_wdata  = v.wdata;
        bus.ex_valid  = 1'b1;
        #1;
        chk({v.name, " busy@offer"}, 32'(bus.lsu_busy), 32'(!v.mis));
        @(posedge clk);
        #1 bus.ex_valid = 1'b0;

        for (int i = 0; i < int'(WMAX) + 4; i++) begin
            @(negedge clk);
            bus.dm_ack = 1'b0;
            if (bus.dm_req) begin
                if (nreq == 0) begin
                    be_seen = bus.dm_be; ad_seen = bus.dm_addr;
                    wd_seen = bus.dm_wdata; we_seen = bus.dm_we;
                end
                if (bus.dm_be !== v.be || bus.dm_addr !== {v.addr[31:2], 2'b00} ||
                    bus.dm_we !== v.we || (v.we && bus.dm_wdata !== v.exp_wd)) bad++;
                nreq++;
                if (nreq == v.delay) begin
                    bus.dm_ack   = 1'b1;
                    bus.dm_rdata = v.rdata;
                end
            end else if (tmo && nreq >= WMAX) begin
                bus.dm_ack   = 1'b1;
                bus.dm_rdata = ~v.rdata;
            end
            if (bus.lsu_busy) nbusy++;
            if (bus.wb_valid) begin nwb++; wb_idx = i; wb_seen = bus.wb_data; end
            if (bus.exc_misalign) begin nmis++; mis_idx = i; end
            if (bus.exc_timeout) nto++;
        end
        bus.dm_ack = 1'b0;

        chk({v.name, " req_cycles"}, 32'(nreq), v.mis ? 32'd0 : (acked ? 32'(v.delay) : 32'(WMAX)));
        chk({v.name, " busy_cycles"}, 32'(nbusy), v.mis ? 32'd0 : (acked ? 32'(v.delay + 1) : 32'(WMAX)));
        chk({v.name, " misalign"}, 32'(nmis), 32'(v.mis));
        chk({v.name, " mis_idx"}, 32'(mis_idx), v.mis ? 32'd0 : 32'hFFFF_FFFF);
        chk({v.name, " timeout"}, 32'(nto), 32'(tmo));
        chk({v.name, " wb_idx"}, 32'(wb_idx), (acked && !v.we) ? 32'(v.delay) : 32'hFFFF_FFFF);
        chk({v.name, " wb_count"}, 32'(nwb), 32'(acked && !v.we));
        if (!v.mis) begin
            chk({v.name, " dm_be"}, 32'(be_seen), 32'(v.be));
            chk({v.name, " dm_addr"}, ad_seen, {v.addr[31:2], 2'b00});
            chk({v.name, " dm_we"}, 32'(we_seen), 32'(v.we));
            chk({v.name, " bus_unstable"}, 32'(bad), 32'd0);
            if (v.we) chk({v.name, " dm_wdata"}, wd_seen, v.exp_wd);
        end
        if (acked && !v.we) begin
            chk({v.name, " wb_data"}, wb_seen, v.exp_wb);
            last_wb = v.exp_wb;
        end
        chk({v.name, " wb_hold"}, bus.wb_data, last_wb);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t r;
        last_wb       = '0;
        rst           = 1'b1;
        bus.ex_valid  = 1'b1;
        bus.ex_we     = 1'b0;
        bus.ex_size   = 2'b00;
        bus.ex_signed = 1'b0;
        bus.ex_addr   = 32'h0000_0100;
        bus.ex_wdata  = '0;
        bus.dm_ack    = 1'b0;
        bus.dm_rdata  = '0;

        // Reset with an aligned op offered: must be ignored.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk("post_reset dm_req", 32'(bus.dm_req), 32'd0);

        tbl[0] = '{name:"LB_s_1003", we:0, size:2'b10, sgn:1, addr:32'h1003, wdata:0, rdata:32'h80FF1234,
                   delay:1, mis:0, be:4'b1000, exp_wd:0, exp_wb:32'hFFFFFF80};
        tbl[1] = '{name:"LH_u_2002", we:0, size:2'b01, sgn:0, addr:32'h2002, wdata:0, rdata:32'hBEEF0000,
                   delay:1, mis:0, be:4'b1100, exp_wd:0, exp_wb:32'h0000BEEF};
        tbl[2] = '{name:"LH_s_2002", we:0, size:2'b01, sgn:1, addr:32'h2002, wdata:0, rdata:32'hBEEF0000,
                   delay:2, mis:0, be:4'b1100, exp_wd:0, exp_wb:32'hFFFFBEEF};
        tbl[3] = '{name:"SB_5", we:1, size:2'b10, sgn:0, addr:32'h5, wdata:32'h000000AB, rdata:0,
                   delay:3, mis:0, be:4'b0010, exp_wd:32'hABABABAB, exp_wb:0};
        tbl[4] = '{name:"LW_6_mis", we:0, size:2'b00, sgn:0, addr:32'h6, wdata:0, rdata:0,
                   delay:1, mis:1, be:4'b0000, exp_wd:0, exp_wb:0};
        tbl[5] = '{name:"SZ11_mis", we:1, size:2'b11, sgn:0, addr:32'h0, wdata:32'h1, rdata:0,
                   delay:1, mis:1, be:4'b0000, exp_wd:0, exp_wb:0};
        tbl[6] = '{name:"SW_timeout", we:1, size:2'b00, sgn:0, addr:32'h100, wdata:32'hDEADBEEF, rdata:32'h5555AAAA,
                   delay:9, mis:0, be:4'b1111, exp_wd:32'hDEADBEEF, exp_wb:0};
        tbl[7] = '{name:"LW_ack_last", we:0, size:2'b00, sgn:1, addr:32'h10, wdata:0, rdata:32'h12345678,
                   delay:4, mis:0, be:4'b1111, exp_wd:0, exp_wb:32'h12345678};
        tbl[8] = '{name:"SH_2", we:1, size:2'b01, sgn:0, addr:32'h2, wdata:32'h1234CDEF, rdata:0,
                   delay:2, mis:0, be:4'b1100, exp_wd:32'hCDEFCDEF, exp_wb:0};
        tbl[9] = '{name:"LBU_2", we:0, size:2'b10, sgn:0, addr:32'h2, wdata:0, rdata:32'h00A50000,
                   delay:1, mis:0, be:4'b0100, exp_wd:0, exp_wb:32'h000000A5};

        foreach (tbl[i]) run_op(tbl[i]);

        // Reset during REQ of an LW at 0x40, with a late ack and an offered op.
        @(negedge clk);
        bus.ex_we = 1'b0; bus.ex_size = 2'b00; bus.ex_signed = 1'b0;
        bus.ex_addr = 32'h40; bus.ex_valid = 1'b1;
        @(posedge clk);
        #1 bus.ex_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid dm_req_before", 32'(bus.dm_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        bus.ex_addr = 32'h80; bus.ex_valid = 1'b1;
        bus.dm_ack = 1'b1; bus.dm_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_hold dm_req", 32'(bus.dm_req), 32'd0);
        chk("rst_hold busy", 32'(bus.lsu_busy), 32'd0);
        rst = 1'b0;
        bus.ex_valid = 1'b0;
        @(negedge clk);
        chk("late_ack dm_req", 32'(bus.dm_req), 32'd0);
        chk("late_ack wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("late_ack wb_data", bus.wb_data, 32'd0);
        bus.dm_ack = 1'b0;
        last_wb = '0;
        r = '{name:"LW_40_after_rst", we:0, size:2'b00, sgn:0, addr:32'h40, wdata:0, rdata:32'hCAFEF00D,
              delay:2, mis:0, be:4'b1111, exp_wd:0, exp_wb:32'hCAFEF00D};
        run_op(r);

        for (int n = 0; n < 60; n++) begin
            r.name   = $sformatf("rand%0d", n);
            r.we     = 1'($urandom_range(0, 1));
            r.size   = 2'($urandom_range(0, 3));
            r.sgn    = 1'($urandom_range(0, 1));
            r.addr   = $urandom;
            r.wdata  = $urandom;
            r.rdata  = $urandom;
            r.delay  = $urandom_range(1, 6);
            r.mis    = m_mis(r.size, r.addr);
            r.be     = m_be(r.size, r.addr);
            r.exp_wd = m_wd(r.size, r.wdata);
            r.exp_wb = m_ld(r.size, r.sgn, r.addr, r.rdata);
            run_op(r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter WAIT_MAX, default 255: the maximum number of REQ-state cycles without dm_ack before the access SHALL be aborted; legal range 1..255.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 ex_valid  in  1  memory operation offered by execute stage.
REQ-005 ex_we  in  1  operation type: 1 = store, 0 = load.
REQ-006 ex_size  in  2  access size: 00 = word, 01 = half, 10 = byte, 11 = illegal.
REQ-007 ex_signed  in  1  load extension: 1 = sign-extend, 0 = zero-extend.
REQ-008 ex_addr  in  32  byte address.
REQ-009 ex_wdata  in  32  store data, right-justified.
REQ-010 lsu_busy  out  1  pipeline stall request.
REQ-011 dm_req  out  1  data-memory request, held until acknowledged.
REQ-012 dm_we  out  1  data-memory write enable.
REQ-013 dm_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 dm_be  out  4  byte enables.
REQ-015 dm_wdata  out  32  lane-replicated store data.
REQ-016 dm_ack  in  1  memory acknowledge; dm_rdata is valid in the same cycle.
REQ-017 dm_rdata  in  32  read word.
REQ-018 wb_valid  out  1  one-cycle pulse indicating load result valid.
REQ-019 wb_data  out  32  extended load result.
REQ-020 exc_misalign  out  1  one-cycle pulse: misaligned or illegal access.
REQ-021 exc_timeout  out  1  one-cycle pulse: access aborted.

Function
REQ-022 FSM states SHALL be IDLE, REQ and DONE; ex_* inputs SHALL be sampled only in IDLE.
REQ-023 Alignment check: a request SHALL be misaligned if it is a half access with addr[0]=1, a word access with addr[1:0]≠00, or ex_size=11.
REQ-024 IDLE with ex_valid and an aligned request: the block SHALL register op, size, signed, addr and wdata and go to REQ.
REQ-025 IDLE with ex_valid and a misaligned request: exc_misalign SHALL pulse next cycle, no dm_req SHALL be issued, and the FSM SHALL stay in IDLE.
REQ-026 lsu_busy SHALL be combinational: state≠IDLE, OR (IDLE and ex_valid and aligned).
REQ-027 REQ: dm_req SHALL be 1 and dm_we, dm_addr, dm_be and dm_wdata SHALL be stable until the dm_ack cycle.
REQ-028 REQ with dm_ack: a load SHALL register the extended data into wb_data; the FSM SHALL go to DONE.
REQ-029 DONE: wb_valid SHALL be 1 for loads and 0 for stores; the FSM SHALL go to IDLE next cycle; minimum occupancy is accept cycle + 1 REQ cycle + DONE.
REQ-030 dm_be encoding:
  - byte: 1<<addr[1:0]
  - half: 0011 when addr[1]=0, 1100 when addr[1]=1
  - word: 1111
  - the same encoding SHALL apply to loads.
REQ-031 dm_wdata encoding:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
REQ-032 Load extraction: byte = dm_rdata[8*addr[1:0]+:8]; half = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0]; then extend to 32 bits per ex_signed; word SHALL pass through unchanged.
REQ-033 Timeout: a cycle counter SHALL clear on REQ entry and increment in each REQ cycle without dm_ack. After WAIT_MAX REQ cycles without dm_ack:
  - dm_req SHALL drop;
  - exc_timeout SHALL pulse;
  - the FSM SHALL go to IDLE, with no wb_valid.
REQ-034 An ack in the same cycle as the final timeout cycle SHALL count as success, with no exc_timeout.
REQ-035 dm_ack SHALL be ignored in IDLE and DONE.
REQ-036 wb_data SHALL hold its value until the next load completes.

Reset
REQ-037 When rst is sampled high, on that clock edge: state SHALL be IDLE, the counter 0, and dm_req, dm_we, dm_addr, dm_be, dm_wdata, wb_valid, wb_data, exc_misalign and exc_timeout all 0.
REQ-038 While rst is high, lsu_busy SHALL be 0 and ex_valid SHALL be ignored.
REQ-039 Reset mid-operation SHALL abandon the access without wb_valid or exception; a late dm_ack after reset SHALL be ignored.

Verification
REQ-040 Signed LB, addr 0x1003, ack 1 cycle after dm_req, dm_rdata 0x80FF1234 -> dm_be 1000, dm_addr 0x1000, wb_valid pulse, wb_data 0xFFFFFF80.
REQ-041 Unsigned LH, addr 0x2002, dm_rdata 0xBEEF0000 -> dm_be 1100, wb_data 0x0000BEEF; the signed variant yields 0xFFFFBEEF.
REQ-042 SB, addr 0x5, wdata 0x000000AB, ack after 3 cycles -> dm_req high 3 cycles, dm_be 0010, dm_wdata 0xABABABAB, dm_we 1, no wb_valid, lsu_busy low after DONE.
REQ-043 LW at addr 0x6, and any access with ex_size=11 -> exc_misalign pulse next cycle, dm_req stays 0, lsu_busy stays 0.
REQ-044 WAIT_MAX=4, no ack -> dm_req high exactly 4 cycles, exc_timeout pulse, return to IDLE; a late dm_ack SHALL be ignored.
REQ-045 rst asserted during REQ for an LW at 0x40 -> next cycle dm_req=0, all outputs 0, no wb_valid; a new request after reset completes normally.
